// File: rtl/x1spi_seq_pkg.sv
// rtl/x1spi_seq_pkg.sv - shared state encodings, opcodes and defaults for the x1 SPI sequencer
package x1spi_seq_pkg;

    localparam int ST_W = 6;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 6'b000001,
        ST_GRANT = 6'b000010,
        ST_ISSUE = 6'b000100,
        ST_WAIT  = 6'b001000,
        ST_GAP   = 6'b010000,
        ST_DONE  = 6'b100000
    } state_t;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    localparam int DEF_GAP_CYC = 2;
    localparam int DEF_TMO_CYC = 4096;

    // A request overflows when its last byte address would pass 24'hFFFFFF.
    function automatic logic addr_overflow(input logic [23:0] addr, input logic [31:0] len);
        return (addr != 24'd0) && (len != 32'd0) && (({8'd0, addr} + len) > 32'h0100_0000);
    endfunction

endpackage

// File: rtl/x1spi_seq_arb.sv
// rtl/x1spi_seq_arb.sv - 2-way fixed-priority / round-robin arbiter with last-grant register
module x1spi_seq_arb #(
    parameter int RR = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_take,
    output logic o_gnt
);

    logic r_last;

    // o_gnt: 0 selects R0, 1 selects R1; only meaningful while a request is present.
    always_comb begin
        o_gnt = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt = (RR != 0) ? ~r_last : 1'b0;
        end else begin
            o_gnt = i_req1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b0;
        end else if (i_take) begin
            r_last <= o_gnt;
        end
    end

endmodule

// File: rtl/x1spi_seq.sv
// rtl/x1spi_seq.sv - two-requester sequencer splitting requests into single-byte x1 SPI engine transactions
module x1spi_seq
    import x1spi_seq_pkg::*;
#(
    parameter int RR      = 0,
    parameter int LEN_W   = 9,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_req,
    output logic             r0_ack,
    input  logic [7:0]       r0_cmd,
    input  logic [23:0]      r0_addr,
    input  logic [2:0]       r0_dummy,
    input  logic [LEN_W-1:0] r0_len,
    output logic [7:0]       r0_rdata,
    output logic             r0_rvalid,
    output logic             r0_done,
    output logic             r0_err,
    input  logic             r1_req,
    output logic             r1_ack,
    input  logic [7:0]       r1_cmd,
    input  logic [23:0]      r1_addr,
    input  logic [2:0]       r1_dummy,
    input  logic [LEN_W-1:0] r1_len,
    output logic [7:0]       r1_rdata,
    output logic             r1_rvalid,
    output logic             r1_done,
    output logic             r1_err,
    output logic             eng_start,
    output logic [7:0]       eng_cmd,
    output logic [23:0]      eng_addr,
    output logic [2:0]       eng_dummy_num,
    output logic             eng_exist_rx_data,
    input  logic             eng_finish,
    input  logic [7:0]       eng_data_in
);

    localparam int CNT_W = $clog2(TMO_CYC + GAP_CYC + 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_owner;
    logic [7:0]       r_cmd;
    logic [23:0]      r_addr;
    logic [2:0]       r_dummy;
    logic [LEN_W-1:0] r_len;
    logic             r_addr_en;
    logic [LEN_W-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             r_rvalid;
    logic [7:0]       r_rdata;

    logic             w_take;
    logic             w_gnt;
    logic             w_last;
    logic             w_tmo;
    logic [7:0]       w_cmd;
    logic [23:0]      w_addr;
    logic [2:0]       w_dummy;
    logic [LEN_W-1:0] w_len;

    x1spi_seq_arb #(
        .RR(RR)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req0(r0_req),
        .i_req1(r1_req),
        .i_take(w_take),
        .o_gnt (w_gnt)
    );

    assign w_cmd   = r_owner ? r1_cmd   : r0_cmd;
    assign w_addr  = r_owner ? r1_addr  : r0_addr;
    assign w_dummy = r_owner ? r1_dummy : r0_dummy;
    assign w_len   = r_owner ? r1_len   : r0_len;
    assign w_last  = (r_rem == LEN_W'(1));
    assign w_tmo   = (r_cnt == CNT_W'(TMO_CYC - 1));

    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    w_take = 1'b1;
                    w_next = ST_GRANT;
                end
            end
            ST_GRANT: w_next = ST_ISSUE;
            // An overflowing request passes through ISSUE with the start pulse suppressed.
            ST_ISSUE: w_next = r_err ? ST_DONE : ST_WAIT;
            ST_WAIT: begin
                if (eng_finish) begin
                    w_next = w_last ? ST_DONE : ST_GAP;
                end else if (w_tmo) begin
                    w_next = ST_DONE;
                end
            end
            ST_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_cmd     <= 8'd0;
            r_addr    <= 24'd0;
            r_dummy   <= 3'd0;
            r_len     <= '0;
            r_addr_en <= 1'b0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 8'd0;
        end else begin
            r_state  <= w_next;
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_owner <= w_gnt;
                    end
                end
                ST_GRANT: begin
                    r_cmd     <= w_cmd;
                    r_addr    <= w_addr;
                    r_dummy   <= w_dummy;
                    r_len     <= w_len;
                    r_addr_en <= (w_addr != 24'd0);
                    r_rem     <= (w_len == '0) ? LEN_W'(1) : w_len;
                    r_err     <= addr_overflow(w_addr, 32'(w_len));
                end
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (eng_finish) begin
                        r_cnt <= '0;
                        r_rem <= r_rem - LEN_W'(1);
                        if (r_len != '0) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= eng_data_in;
                        end
                        if (!w_last && r_addr_en) begin
                            r_addr <= r_addr + 24'd1;
                        end
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                ST_GAP:  r_cnt <= r_cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign r0_ack    = (r_state == ST_GRANT) && !r_owner;
    assign r1_ack    = (r_state == ST_GRANT) &&  r_owner;
    assign r0_done   = (r_state == ST_DONE)  && !r_owner;
    assign r1_done   = (r_state == ST_DONE)  &&  r_owner;
    assign r0_err    = r0_done && r_err;
    assign r1_err    = r1_done && r_err;
    assign r0_rvalid = r_rvalid && !r_owner;
    assign r1_rvalid = r_rvalid &&  r_owner;
    assign r0_rdata  = r0_rvalid ? r_rdata : 8'd0;
    assign r1_rdata  = r1_rvalid ? r_rdata : 8'd0;

    assign eng_start         = (r_state == ST_ISSUE) && !r_err;
    assign eng_cmd           = r_cmd;
    assign eng_addr          = r_addr;
    assign eng_dummy_num     = r_dummy;
    assign eng_exist_rx_data = (r_len != '0);

endmodule

// File: tb/tb_x1spi_seq.sv
// tb/tb_x1spi_seq.sv - self-checking scoreboard bench for x1spi_seq
module tb_x1spi_seq;
    import x1spi_seq_pkg::*;

    localparam int LEN_W   = 9;
    localparam int GAP     = 2;
    localparam int TMO     = 16;
    localparam int ENG_LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // DUT A: fixed priority
    logic             r0_req = 1'b0, r1_req = 1'b0;
    logic [7:0]       r0_cmd = 8'd0, r1_cmd = 8'd0;
    logic [23:0]      r0_addr = 24'd0, r1_addr = 24'd0;
    logic [2:0]       r0_dummy = 3'd0, r1_dummy = 3'd0;
    logic [LEN_W-1:0] r0_len = '0, r1_len = '0;
    logic             r0_ack, r1_ack, r0_rvalid, r1_rvalid, r0_done, r1_done, r0_err, r1_err;
    logic [7:0]       r0_rdata, r1_rdata;
    logic             eng_start, eng_exist_rx_data;
    logic [7:0]       eng_cmd;
    logic [23:0]      eng_addr;
    logic [2:0]       eng_dummy_num;
    logic             eng_finish = 1'b0;
    logic [7:0]       eng_data_in = 8'd0;

    // DUT B: round robin
    logic             b_r0_req = 1'b0, b_r1_req = 1'b0, b_eng_finish = 1'b0;
    logic [7:0]       b_cmd = OP_WREN;
    logic [23:0]      b_addr = 24'd0;
    logic [2:0]       b_dummy = 3'd0;
    logic [LEN_W-1:0] b_len = '0;
    logic [7:0]       b_data = 8'd0;
    logic             b_r0_ack, b_r1_ack, b_r0_rvalid, b_r1_rvalid, b_r0_done, b_r1_done, b_r0_err, b_r1_err;
    logic [7:0]       b_r0_rdata, b_r1_rdata, b_eng_cmd;
    logic             b_eng_start, b_eng_rx;
    logic [23:0]      b_eng_addr;
    logic [2:0]       b_eng_dummy;

    x1spi_seq #(.RR(0), .LEN_W(LEN_W), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_ack(r0_ack), .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_dummy(r0_dummy),
        .r0_len(r0_len), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid), .r0_done(r0_done), .r0_err(r0_err),
        .r1_req(r1_req), .r1_ack(r1_ack), .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_dummy(r1_dummy),
        .r1_len(r1_len), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid), .r1_done(r1_done), .r1_err(r1_err),
        .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_addr(eng_addr), .eng_dummy_num(eng_dummy_num),
        .eng_exist_rx_data(eng_exist_rx_data), .eng_finish(eng_finish), .eng_data_in(eng_data_in)
    );

    x1spi_seq #(.RR(1), .LEN_W(LEN_W), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .r0_req(b_r0_req), .r0_ack(b_r0_ack), .r0_cmd(b_cmd), .r0_addr(b_addr), .r0_dummy(b_dummy),
        .r0_len(b_len), .r0_rdata(b_r0_rdata), .r0_rvalid(b_r0_rvalid), .r0_done(b_r0_done), .r0_err(b_r0_err),
        .r1_req(b_r1_req), .r1_ack(b_r1_ack), .r1_cmd(b_cmd), .r1_addr(b_addr), .r1_dummy(b_dummy),
        .r1_len(b_len), .r1_rdata(b_r1_rdata), .r1_rvalid(b_r1_rvalid), .r1_done(b_r1_done), .r1_err(b_r1_err),
        .eng_start(b_eng_start), .eng_cmd(b_eng_cmd), .eng_addr(b_eng_addr), .eng_dummy_num(b_eng_dummy),
        .eng_exist_rx_data(b_eng_rx), .eng_finish(b_eng_finish), .eng_data_in(b_data)
    );

    logic [60:0] a_outs, b_outs;
    assign a_outs = {r0_ack, r0_rdata, r0_rvalid, r0_done, r0_err, r1_ack, r1_rdata, r1_rvalid, r1_done, r1_err,
                     eng_start, eng_cmd, eng_addr, eng_dummy_num, eng_exist_rx_data};
    assign b_outs = {b_r0_ack, b_r0_rdata, b_r0_rvalid, b_r0_done, b_r0_err, b_r1_ack, b_r1_rdata, b_r1_rvalid,
                     b_r1_done, b_r1_err, b_eng_start, b_eng_cmd, b_eng_addr, b_eng_dummy, b_eng_rx};

    // Scoreboard: {cmd, dummy, rx, addr} per expected engine start; bytes per requester.
    logic [35:0] exp_eng_q[$];
    logic [7:0]  exp_rd0_q[$], exp_rd1_q[$], eng_data_q[$];
    int          start_cyc_q[$], fin_cyc_q[$], rv_cyc_q[$];
    int          n_start = 0, done0_cnt = 0, done1_cnt = 0;
    bit          eng_en = 1'b1;

    initial forever begin : mon_a
        logic [35:0] e;
        logic [7:0]  d;
        @(negedge clk);
        if (eng_start) begin
            n_start++;
            start_cyc_q.push_back(cyc);
            n_total++;
            if (exp_eng_q.size() == 0) begin
                $display("FAIL eng_start_unexpected: got addr %h cmd %h, expected no start", eng_addr, eng_cmd);
            end else begin
                e = exp_eng_q.pop_front();
                if ({eng_cmd, eng_dummy_num, eng_exist_rx_data, eng_addr} !== e)
                    $display("FAIL eng_fields: got %h, expected %h",
                             {eng_cmd, eng_dummy_num, eng_exist_rx_data, eng_addr}, e);
                else n_pass++;
            end
        end
        if (r0_rvalid) begin
            rv_cyc_q.push_back(cyc);
            n_total++;
            d = (exp_rd0_q.size() != 0) ? exp_rd0_q.pop_front() : 8'hxx;
            if (r0_rdata !== d) $display("FAIL r0_rdata: got %h, expected %h", r0_rdata, d);
            else n_pass++;
        end
        if (r1_rvalid) begin
            rv_cyc_q.push_back(cyc);
            n_total++;
            d = (exp_rd1_q.size() != 0) ? exp_rd1_q.pop_front() : 8'hxx;
            if (r1_rdata !== d) $display("FAIL r1_rdata: got %h, expected %h", r1_rdata, d);
            else n_pass++;
        end
        if (r0_done) done0_cnt++;
        if (r1_done) done1_cnt++;
    end

    initial forever begin : eng_a
        @(negedge clk);
        if (eng_start && eng_en) begin
            repeat (ENG_LAT) @(negedge clk);
            eng_data_in = (eng_data_q.size() != 0) ? eng_data_q.pop_front() : 8'h00;
            eng_finish = 1'b1;
            fin_cyc_q.push_back(cyc);
            @(negedge clk);
            eng_finish = 1'b0;
        end
    end

    initial forever begin : eng_b
        @(negedge clk);
        if (b_eng_start) begin
            repeat (2) @(negedge clk);
            b_eng_finish = 1'b1;
            @(negedge clk);
            b_eng_finish = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        start_cyc_q.delete();
        fin_cyc_q.delete();
        rv_cyc_q.delete();
    endtask

    task automatic transfer(input bit port, input logic [7:0] cmd, input logic [23:0] addr,
                            input logic [2:0] dummy, input logic [LEN_W-1:0] len,
                            output int req_cyc, output int ack_cyc, output int done_cyc, output logic err);
        ack_cyc = -1;
        done_cyc = -1;
        err = 1'bx;
        if (port) begin
            r1_cmd = cmd; r1_addr = addr; r1_dummy = dummy; r1_len = len; r1_req = 1'b1;
        end else begin
            r0_cmd = cmd; r0_addr = addr; r0_dummy = dummy; r0_len = len; r0_req = 1'b1;
        end
        req_cyc = cyc;
        for (int i = 0; i < 200 && ack_cyc < 0; i++) begin
            @(negedge clk);
            if (port ? r1_ack : r0_ack) begin
                ack_cyc = cyc;
                if (port) r1_req = 1'b0; else r0_req = 1'b0;
            end
        end
        for (int i = 0; i < 400 && done_cyc < 0 && ack_cyc >= 0; i++) begin
            @(negedge clk);
            if (port ? r1_done : r0_done) begin
                done_cyc = cyc;
                err = port ? r1_err : r0_err;
            end
        end
        if (port) r1_req = 1'b0; else r0_req = 1'b0;
        n_total++;
        if (done_cyc < 0) $display("FAIL transfer_r%0d_timeout: ack cyc %0d, done never seen", port, ack_cyc);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_total++;
        if (a_outs !== '0) $display("FAIL reset_outputs_a: got %h, expected 0", a_outs);
        else n_pass++;
        n_total++;
        if (b_outs !== '0) $display("FAIL reset_outputs_b: got %h, expected 0", b_outs);
        else n_pass++;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_multibyte_read();
        int rq, ak, dn, d0;
        logic er;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            exp_eng_q.push_back({OP_READ, 3'd0, 1'b1, 24'h000100 + 24'(i)});
            eng_data_q.push_back(8'hA1 + 8'(i));
            exp_rd0_q.push_back(8'hA1 + 8'(i));
        end
        d0 = done0_cnt;
        transfer(1'b0, OP_READ, 24'h000100, 3'd0, 9'd3, rq, ak, dn, er);
        tick(4);
        n_total++;
        if (ak - rq !== 1) $display("FAIL read_ack_latency: got %0d, expected 1", ak - rq);
        else n_pass++;
        n_total++;
        if (start_cyc_q.size() !== 3) $display("FAIL read_start_count: got %0d, expected 3", start_cyc_q.size());
        else n_pass++;
        n_total++;
        if (start_cyc_q[0] - ak !== 1) $display("FAIL read_first_start: got %0d, expected 1", start_cyc_q[0] - ak);
        else n_pass++;
        for (int i = 1; i < 3; i++) begin
            n_total++;
            if (start_cyc_q[i] - start_cyc_q[i-1] !== ENG_LAT + GAP + 1)
                $display("FAIL read_start_spacing%0d: got %0d, expected %0d", i,
                         start_cyc_q[i] - start_cyc_q[i-1], ENG_LAT + GAP + 1);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (rv_cyc_q[i] !== fin_cyc_q[i] + 1)
                $display("FAIL read_rvalid_latency%0d: got cyc %0d, expected %0d", i, rv_cyc_q[i], fin_cyc_q[i] + 1);
            else n_pass++;
        end
        n_total++;
        if (dn !== fin_cyc_q[2] + 1) $display("FAIL read_done_latency: got cyc %0d, expected %0d", dn, fin_cyc_q[2] + 1);
        else n_pass++;
        n_total++;
        if (er !== 1'b0) $display("FAIL read_err: got %b, expected 0", er);
        else n_pass++;
        n_total++;
        if (done0_cnt - d0 !== 1) $display("FAIL read_done_count: got %0d, expected 1", done0_cnt - d0);
        else n_pass++;
        n_total++;
        if (exp_eng_q.size() + exp_rd0_q.size() !== 0)
            $display("FAIL read_leftover: got %0d pending, expected 0", exp_eng_q.size() + exp_rd0_q.size());
        else n_pass++;
    endtask

    task automatic test_fixed_priority();
        int rq0, a0, d0, rq1, a1, d1;
        logic e0, e1;
        clear_logs();
        exp_eng_q.push_back({OP_RDSR, 3'd2, 1'b1, 24'h0});
        exp_eng_q.push_back({OP_RDSR, 3'd2, 1'b1, 24'h0});
        eng_data_q.push_back(8'h11);
        eng_data_q.push_back(8'h22);
        exp_rd0_q.push_back(8'h11);
        exp_rd1_q.push_back(8'h22);
        fork
            transfer(1'b0, OP_RDSR, 24'h0, 3'd2, 9'd1, rq0, a0, d0, e0);
            transfer(1'b1, OP_RDSR, 24'h0, 3'd2, 9'd1, rq1, a1, d1, e1);
        join
        tick(2);
        n_total++;
        if (a0 - rq0 !== 1) $display("FAIL prio_r0_ack: got %0d, expected 1", a0 - rq0);
        else n_pass++;
        n_total++;
        if (a1 !== d0 + 2) $display("FAIL prio_r1_ack: got cyc %0d, expected %0d", a1, d0 + 2);
        else n_pass++;
        n_total++;
        if ({e0, e1} !== 2'b00) $display("FAIL prio_err: got %b, expected 00", {e0, e1});
        else n_pass++;
        n_total++;
        if (exp_rd0_q.size() + exp_rd1_q.size() !== 0)
            $display("FAIL prio_leftover: got %0d pending, expected 0", exp_rd0_q.size() + exp_rd1_q.size());
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int acks[$];
        int r1_acks = 0, dones = 0, errs = 0;
        int exp_order[3] = '{1, 0, 1};
        b_r0_req = 1'b1;
        b_r1_req = 1'b1;
        for (int i = 0; i < 300 && dones < 3; i++) begin
            @(negedge clk);
            if (b_r0_ack) begin
                acks.push_back(0);
                b_r0_req = 1'b0;
            end
            if (b_r1_ack) begin
                acks.push_back(1);
                r1_acks++;
                if (r1_acks > 1) b_r1_req = 1'b0;
            end
            if (b_r0_done || b_r1_done) dones++;
            if (b_r0_err || b_r1_err) errs++;
        end
        b_r0_req = 1'b0;
        b_r1_req = 1'b0;
        n_total++;
        if (dones !== 3) $display("FAIL rr_done_count: got %0d, expected 3", dones);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (acks.size() <= i || acks[i] !== exp_order[i])
                $display("FAIL rr_order%0d: got %0d, expected R%0d", i, (acks.size() > i) ? acks[i] : -1, exp_order[i]);
            else n_pass++;
        end
        n_total++;
        if (errs !== 0) $display("FAIL rr_err: got %0d, expected 0", errs);
        else n_pass++;
    endtask

    task automatic test_cmd_only();
        int rq, ak, dn;
        logic er;
        clear_logs();
        exp_eng_q.push_back({OP_WREN, 3'd0, 1'b0, 24'h0});
        transfer(1'b1, OP_WREN, 24'h0, 3'd0, 9'd0, rq, ak, dn, er);
        tick(3);
        n_total++;
        if (start_cyc_q.size() !== 1) $display("FAIL cmd_start_count: got %0d, expected 1", start_cyc_q.size());
        else n_pass++;
        n_total++;
        if (dn !== fin_cyc_q[0] + 1) $display("FAIL cmd_done_latency: got cyc %0d, expected %0d", dn, fin_cyc_q[0] + 1);
        else n_pass++;
        n_total++;
        if ({er, rv_cyc_q.size() != 0} !== 2'b00)
            $display("FAIL cmd_err_rvalid: got err %b rvalids %0d, expected 0/0", er, rv_cyc_q.size());
        else n_pass++;
    endtask

    task automatic test_overflow();
        int rq, ak, dn, ns;
        logic er;
        clear_logs();
        ns = n_start;
        transfer(1'b0, OP_READ, 24'hFFFFFE, 3'd0, 9'd3, rq, ak, dn, er);
        tick(3);
        n_total++;
        if (dn - ak !== 2) $display("FAIL ovf_done_latency: got %0d, expected 2", dn - ak);
        else n_pass++;
        n_total++;
        if (er !== 1'b1) $display("FAIL ovf_err: got %b, expected 1", er);
        else n_pass++;
        n_total++;
        if (n_start !== ns) $display("FAIL ovf_no_start: got %0d starts, expected 0", n_start - ns);
        else n_pass++;
        // Ending exactly at FFFFFF is legal.
        exp_eng_q.push_back({OP_READ, 3'd0, 1'b1, 24'hFFFFFE});
        exp_eng_q.push_back({OP_READ, 3'd0, 1'b1, 24'hFFFFFF});
        eng_data_q.push_back(8'h5E);
        eng_data_q.push_back(8'h5F);
        exp_rd0_q.push_back(8'h5E);
        exp_rd0_q.push_back(8'h5F);
        transfer(1'b0, OP_READ, 24'hFFFFFE, 3'd0, 9'd2, rq, ak, dn, er);
        tick(2);
        n_total++;
        if ({er, 3'(exp_eng_q.size())} !== 4'd0)
            $display("FAIL edge_top_addr: got err %b pending %0d, expected 0/0", er, exp_eng_q.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
        int rq, ak, dn;
        logic er;
        clear_logs();
        eng_en = 1'b0;
        exp_eng_q.push_back({OP_READ, 3'd0, 1'b1, 24'h000200});
        transfer(1'b0, OP_READ, 24'h000200, 3'd0, 9'd2, rq, ak, dn, er);
        n_total++;
        if (dn - start_cyc_q[0] !== TMO + 1)
            $display("FAIL tmo_latency: got %0d, expected %0d", dn - start_cyc_q[0], TMO + 1);
        else n_pass++;
        n_total++;
        if (er !== 1'b1) $display("FAIL tmo_err: got %b, expected 1", er);
        else n_pass++;
        eng_en = 1'b1;
        tick(2);
        exp_eng_q.push_back({OP_RDSR, 3'd0, 1'b1, 24'h0});
        eng_data_q.push_back(8'h5A);
        exp_rd1_q.push_back(8'h5A);
        transfer(1'b1, OP_RDSR, 24'h0, 3'd0, 9'd1, rq, ak, dn, er);
        tick(2);
        n_total++;
        if ({er, 3'(exp_rd1_q.size())} !== 4'd0)
            $display("FAIL tmo_recovery: got err %b pending %0d, expected 0/0", er, exp_rd1_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int rq, ak, dn, ns, d0, t;
        logic er;
        clear_logs();
        eng_en = 1'b0;
        exp_eng_q.push_back({OP_READ, 3'd0, 1'b1, 24'h000300});
        r0_cmd = OP_READ; r0_addr = 24'h000300; r0_dummy = 3'd0; r0_len = 9'd4; r0_req = 1'b1;
        t = 0;
        while (!r0_ack && t < 50) begin
            @(negedge clk);
            t++;
        end
        r0_req = 1'b0;
        t = 0;
        while (!eng_start && t < 50) begin
            @(negedge clk);
            t++;
        end
        tick(3);
        ns = n_start;
        d0 = done0_cnt;
        rst_n = 1'b0;
        tick(1);
        n_total++;
        if (a_outs !== '0) $display("FAIL rst_mid_outputs: got %h, expected 0", a_outs);
        else n_pass++;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        n_total++;
        if ({done0_cnt - d0, n_start - ns} !== {32'd0, 32'd0})
            $display("FAIL rst_mid_quiet: got dones %0d starts %0d, expected 0/0", done0_cnt - d0, n_start - ns);
        else n_pass++;
        eng_en = 1'b1;
        exp_eng_q.push_back({OP_READ, 3'd0, 1'b1, 24'h000400});
        exp_eng_q.push_back({OP_READ, 3'd0, 1'b1, 24'h000401});
        eng_data_q.push_back(8'hC1);
        eng_data_q.push_back(8'hC2);
        exp_rd0_q.push_back(8'hC1);
        exp_rd0_q.push_back(8'hC2);
        transfer(1'b0, OP_READ, 24'h000400, 3'd0, 9'd2, rq, ak, dn, er);
        tick(2);
        n_total++;
        if ({er, 3'(exp_rd0_q.size()), 3'(exp_eng_q.size())} !== 7'd0)
            $display("FAIL rst_mid_after: got err %b pending %0d/%0d, expected 0", er,
                     exp_rd0_q.size(), exp_eng_q.size());
        else n_pass++;
    endtask

    initial begin
        tick(1);
        test_reset();
        test_multibyte_read();
        test_fixed_priority();
        test_round_robin();
        test_cmd_only();
        test_overflow();
        test_timeout();
        test_reset_mid();
        tick(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
